register_file_mp: RTL and testbench

Parametrised multi-port register file for the core's decode/writeback boundary. It generalises the core register file to N read ports and M write ports. Same-cycle write-to-read bypass is selectable by parameter, and write-port conflicts resolve by fixed priority. An internal per-register busy scoreboard lets decode detect read-after-write hazards against instructions still in flight. It sits between the FD and MW pipeline registers, with Core choosing what drives each write port.

---
 rtl/register_file_mp_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 47 ++++
 rtl/register_file_mp.sv | 99 +++++++++
 tb/tb_register_file_mp.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_mp_pkg.sv
// Shared defaults for the multi-port register file.
// Holds the default geometry used when the top is instantiated without
// explicit parameters (register count/width, read/write port counts, bypass).
package register_file_mp_pkg;

    localparam int unsigned RF_REG_COUNT    = 32;
    localparam int unsigned RF_REG_SIZE     = 32;
    localparam int unsigned RF_REG_PTR_SIZE = $clog2(RF_REG_COUNT);
    localparam int unsigned RF_NUM_RD       = 3;
    localparam int unsigned RF_NUM_WR       = 2;
    localparam bit          RF_BYPASS       = 1'b1;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard for read-after-write hazard detection.
// Ports:
//   clk, reset_RF_n : clock, asynchronous active-low reset
//   issue_en/dst    : mark issue_dst busy (an in-flight producer left decode)
//   clr_en/wr_addr  : clear the busy bit of wr_addr slice j when clr_en[j]
//   busy_vec        : registered scoreboard state, one bit per register
module rf_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int unsigned REG_COUNT    = RF_REG_COUNT,
    parameter int unsigned REG_PTR_SIZE = RF_REG_PTR_SIZE,
    parameter int unsigned NUM_WR       = RF_NUM_WR
) (
    input  logic                           clk,
    input  logic                           reset_RF_n,
    input  logic                           issue_en,
    input  logic [REG_PTR_SIZE-1:0]        issue_dst,
    input  logic [NUM_WR-1:0]              clr_en,
    input  logic [NUM_WR*REG_PTR_SIZE-1:0] wr_addr,
    output logic [REG_COUNT-1:0]           busy_vec
);

    logic [REG_COUNT-1:0] busy_d;

    // Set is applied after the clears so a same-cycle reissue stays busy:
    // the new producer is younger than the one completing.
    always_comb begin
        busy_d = busy_vec;
        for (int j = 0; j < NUM_WR; j++) begin
            if (clr_en[j]) begin
                busy_d[wr_addr[j*REG_PTR_SIZE +: REG_PTR_SIZE]] = 1'b0;
            end
        end
        if (issue_en) begin
            busy_d[issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_RF_n) begin
        if (!reset_RF_n) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_d;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file for the decode/writeback boundary.
// Ports:
//   clk, reset_RF_n       : clock, asynchronous active-low reset
//   init_R0/init_R0_data  : highest-priority load of R0
//   rd_addr/rd_data       : NUM_RD combinational read ports, port k in slice k
//   rd_busy               : scoreboard bit of each read port's register
//   wr_en/wr_addr/wr_data : NUM_WR write ports, higher index wins on conflict
//   issue_en/issue_dst    : mark a destination busy
//   clr_en                : clear busy for wr_addr slice j
//   busy_vec              : full scoreboard state
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int unsigned REG_COUNT    = RF_REG_COUNT,
    parameter int unsigned REG_SIZE     = RF_REG_SIZE,
    parameter int unsigned REG_PTR_SIZE = $clog2(REG_COUNT),
    parameter int unsigned NUM_RD       = RF_NUM_RD,
    parameter int unsigned NUM_WR       = RF_NUM_WR,
    parameter bit          BYPASS       = RF_BYPASS
) (
    input  logic                           clk,
    input  logic                           reset_RF_n,
    input  logic                           init_R0,
    input  logic [REG_SIZE-1:0]            init_R0_data,
    input  logic [NUM_RD*REG_PTR_SIZE-1:0] rd_addr,
    output logic [NUM_RD*REG_SIZE-1:0]     rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR*REG_PTR_SIZE-1:0] wr_addr,
    input  logic [NUM_WR*REG_SIZE-1:0]     wr_data,
    input  logic                           issue_en,
    input  logic [REG_PTR_SIZE-1:0]        issue_dst,
    input  logic [NUM_WR-1:0]              clr_en,
    output logic [REG_COUNT-1:0]           busy_vec
);

    logic [REG_SIZE-1:0] rf_q     [REG_COUNT];
    logic [REG_SIZE-1:0] fwd_data [REG_COUNT];

    for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
        logic                hit;
        logic [REG_SIZE-1:0] win_data;

        // Ports scanned upward so the highest-index match overwrites; init_R0 last.
        always_comb begin
            hit      = 1'b0;
            win_data = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] &&
                    wr_addr[j*REG_PTR_SIZE +: REG_PTR_SIZE] == REG_PTR_SIZE'(i)) begin
                    hit      = 1'b1;
                    win_data = wr_data[j*REG_SIZE +: REG_SIZE];
                end
            end
            if (i == 0 && init_R0) begin
                hit      = 1'b1;
                win_data = init_R0_data;
            end
        end

        always_ff @(posedge clk or negedge reset_RF_n) begin
            if (!reset_RF_n) begin
                rf_q[i] <= '0;
            end else if (hit) begin
                rf_q[i] <= win_data;
            end
        end

        // Still forwards live write data while reset holds storage at zero.
        assign fwd_data[i] = hit ? win_data : rf_q[i];
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k*REG_SIZE +: REG_SIZE] =
                BYPASS ? fwd_data[rd_addr[k*REG_PTR_SIZE +: REG_PTR_SIZE]]
                       : rf_q[rd_addr[k*REG_PTR_SIZE +: REG_PTR_SIZE]];
            // Registered state only: decode handles same-cycle writes itself.
            rd_busy[k] = busy_vec[rd_addr[k*REG_PTR_SIZE +: REG_PTR_SIZE]];
        end
    end

    rf_scoreboard #(
        .REG_COUNT   (REG_COUNT),
        .REG_PTR_SIZE(REG_PTR_SIZE),
        .NUM_WR      (NUM_WR)
    ) u_scoreboard (
        .clk       (clk),
        .reset_RF_n(reset_RF_n),
        .issue_en  (issue_en),
        .issue_dst (issue_dst),
        .clr_en    (clr_en),
        .wr_addr   (wr_addr),
        .busy_vec  (busy_vec)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: stimulus pushes expected values, a negedge monitor pops and compares.
// Two DUTs share all inputs: one with bypass, one without.
module tb_register_file_mp;

    localparam int unsigned RC = 8;
    localparam int unsigned RS = 8;
    localparam int unsigned RP = 3;
    localparam int unsigned NR = 3;
    localparam int unsigned NW = 2;

    logic           clk = 1'b0;
    logic           reset_RF_n;
    logic           init_R0;
    logic [RS-1:0]  init_R0_data;
    logic [NR*RP-1:0] rd_addr;
    logic [NW-1:0]  wr_en;
    logic [NW*RP-1:0] wr_addr;
    logic [NW*RS-1:0] wr_data;
    logic           issue_en;
    logic [RP-1:0]  issue_dst;
    logic [NW-1:0]  clr_en;

    logic [NR*RS-1:0] rd_data_b, rd_data_n;
    logic [NR-1:0]    rd_busy_b, rd_busy_n;
    logic [RC-1:0]    busy_vec_b, busy_vec_n;

    always #5 clk = ~clk;

    register_file_mp #(
        .REG_COUNT(RC), .REG_SIZE(RS), .REG_PTR_SIZE(RP),
        .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b1)
    ) dut_b (
        .clk(clk), .reset_RF_n(reset_RF_n), .init_R0(init_R0), .init_R0_data(init_R0_data),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_dst(issue_dst), .clr_en(clr_en), .busy_vec(busy_vec_b)
    );

    register_file_mp #(
        .REG_COUNT(RC), .REG_SIZE(RS), .REG_PTR_SIZE(RP),
        .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b0)
    ) dut_n (
        .clk(clk), .reset_RF_n(reset_RF_n), .init_R0(init_R0), .init_R0_data(init_R0_data),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_dst(issue_dst), .clr_en(clr_en), .busy_vec(busy_vec_n)
    );

    // what: 0 rd_data bypass, 1 rd_busy bypass, 2 busy_vec bypass,
    //       3 rd_data no-bypass, 4 busy_vec no-bypass, 5 rd_busy no-bypass
    typedef struct {
        int          what;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        cur;
    string       cur_name;
    logic [31:0] act;

    function automatic logic [31:0] get_act(input int what, input int port);
        case (what)
            0:       return 32'(rd_data_b[port*RS +: RS]);
            1:       return 32'(rd_busy_b[port]);
            2:       return 32'(busy_vec_b);
            3:       return 32'(rd_data_n[port*RS +: RS]);
            4:       return 32'(busy_vec_n);
            default: return 32'(rd_busy_n[port]);
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            cur      = exp_q.pop_front();
            cur_name = name_q.pop_front();
            act      = get_act(cur.what, cur.port);
            n_vec++;
            if (act !== cur.exp) begin
                n_err++;
                $display("FAIL %s (sel %0d port %0d): got 0x%0h, expected 0x%0h",
                         cur_name, cur.what, cur.port, act, cur.exp);
            end
        end
    end

    task automatic push_exp(input int what, input int port, input logic [31:0] e,
                            input string name);
        exp_t x;
        x.what = what;
        x.port = port;
        x.exp  = e;
        exp_q.push_back(x);
        name_q.push_back(name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        clr_en   = '0;
        issue_en = 1'b0;
        init_R0  = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input int d);
        wr_en[p]            = 1'b1;
        wr_addr[p*RP +: RP] = RP'(a);
        wr_data[p*RS +: RS] = RS'(d);
    endtask

    task automatic rd(input int p, input int a);
        rd_addr[p*RP +: RP] = RP'(a);
    endtask

    logic [RS-1:0] m_rf [RC];
    logic [RC-1:0] m_busy;
    logic [RS-1:0] v;
    int            a;

    initial begin
        reset_RF_n   = 1'b0;
        idle();
        init_R0_data = '0;
        rd_addr      = '0;
        wr_addr      = '0;
        wr_data      = '0;
        issue_dst    = '0;
        step();
        push_exp(2, 0, 32'h0, "reset_busy_vec");
        push_exp(0, 0, 32'h0, "reset_rd0");
        step();
        reset_RF_n = 1'b1;
        step();

        // Write R3 = A5 and issue R3.
        wr(0, 3, 'hA5); rd(0, 3); issue_en = 1'b1; issue_dst = 3'd3;
        push_exp(0, 0, 32'hA5, "wr_bypass_same_cycle");
        push_exp(3, 0, 32'h00, "wr_nobypass_old_value");
        step();
        idle();
        push_exp(0, 0, 32'hA5, "wr_stored_b");
        push_exp(3, 0, 32'hA5, "wr_stored_n");
        push_exp(2, 0, 32'h08, "issue_busy_vec");
        push_exp(1, 0, 32'h1, "issue_rd_busy");
        step();
        // Asynchronous reset between edges: checked before the next rising edge.
        reset_RF_n = 1'b0;
        push_exp(0, 0, 32'h0, "async_reset_rd_b");
        push_exp(3, 0, 32'h0, "async_reset_rd_n");
        push_exp(2, 0, 32'h0, "async_reset_busy_vec");
        push_exp(1, 0, 32'h0, "async_reset_rd_busy");
        step();
        reset_RF_n = 1'b1;
        step();

        // Write conflict: port 1 wins.
        wr(0, 5, 'h11); wr(1, 5, 'h22); rd(0, 5);
        push_exp(0, 0, 32'h22, "conflict_bypass");
        push_exp(3, 0, 32'h00, "conflict_nobypass");
        step();
        idle();
        push_exp(0, 0, 32'h22, "conflict_stored_b");
        push_exp(3, 0, 32'h22, "conflict_stored_n");
        step();

        // init_R0 beats write port 1.
        init_R0 = 1'b1; init_R0_data = 8'h07; wr(1, 0, 'h09); rd(0, 0); rd(1, 0);
        push_exp(0, 0, 32'h07, "init_r0_bypass");
        push_exp(3, 1, 32'h00, "init_r0_nobypass");
        step();
        idle();
        push_exp(0, 1, 32'h07, "init_r0_stored_b");
        push_exp(3, 0, 32'h07, "init_r0_stored_n");
        step();

        // Bypass on R2 while port 2 reads R5.
        wr(0, 2, 'h33); rd(0, 2); rd(2, 5);
        push_exp(0, 0, 32'h33, "bypass_r2");
        push_exp(3, 0, 32'h00, "nobypass_r2_old");
        push_exp(0, 2, 32'h22, "port2_r5");
        step();
        idle();
        push_exp(3, 0, 32'h33, "nobypass_r2_next");
        step();

        // Independent ports writing different registers.
        wr(0, 1, 'h44); wr(1, 6, 'h66);
        step();
        idle(); rd(0, 1); rd(1, 6);
        push_exp(3, 0, 32'h44, "two_ports_r1");
        push_exp(3, 1, 32'h66, "two_ports_r6");
        step();

        // Scoreboard sequence on R4.
        issue_en = 1'b1; issue_dst = 3'd4; rd(0, 4);
        push_exp(1, 0, 32'h0, "sb_issue_same_cycle");
        step();
        idle(); issue_en = 1'b1; issue_dst = 3'd4; clr_en[0] = 1'b1; wr_addr[0 +: RP] = 3'd4;
        push_exp(1, 0, 32'h1, "sb_busy_next");
        push_exp(2, 0, 32'h10, "sb_busy_vec");
        step();
        idle(); clr_en[1] = 1'b1; wr_addr[RP +: RP] = 3'd4;
        push_exp(1, 0, 32'h1, "sb_set_wins");
        push_exp(5, 0, 32'h1, "sb_set_wins_n");
        step();
        idle();
        push_exp(1, 0, 32'h0, "sb_cleared");
        push_exp(4, 0, 32'h0, "sb_cleared_vec_n");
        step();

        // Randomised phase against a reference model, from a fresh reset.
        reset_RF_n = 1'b0;
        step();
        reset_RF_n = 1'b1;
        for (int r = 0; r < RC; r++) m_rf[r] = '0;
        m_busy = '0;
        step();
        for (int c = 0; c < 300; c++) begin
            idle();
            for (int p = 0; p < NW; p++) begin
                if ($urandom_range(1, 0) == 1) wr(p, $urandom_range(7, 0), $urandom_range(255, 0));
            end
            clr_en       = wr_en;
            issue_en     = ($urandom_range(1, 0) == 1);
            issue_dst    = RP'($urandom_range(7, 0));
            init_R0      = ($urandom_range(7, 0) == 0);
            init_R0_data = RS'($urandom_range(255, 0));
            for (int k = 0; k < NR; k++) rd(k, $urandom_range(7, 0));
            for (int k = 0; k < NR; k++) begin
                a = int'(rd_addr[k*RP +: RP]);
                v = m_rf[a];
                for (int j = 0; j < NW; j++) begin
                    if (wr_en[j] && int'(wr_addr[j*RP +: RP]) == a) v = wr_data[j*RS +: RS];
                end
                if (a == 0 && init_R0) v = init_R0_data;
                push_exp(0, k, 32'(v), "rand_rd_bypass");
                push_exp(3, k, 32'(m_rf[a]), "rand_rd_nobypass");
            end
            push_exp(2, 0, 32'(m_busy), "rand_busy_vec");
            push_exp(4, 0, 32'(m_busy), "rand_busy_vec_n");
            for (int j = 0; j < NW; j++) begin
                if (wr_en[j]) m_rf[wr_addr[j*RP +: RP]] = wr_data[j*RS +: RS];
            end
            if (init_R0) m_rf[0] = init_R0_data;
            for (int j = 0; j < NW; j++) begin
                if (clr_en[j]) m_busy[wr_addr[j*RP +: RP]] = 1'b0;
            end
            if (issue_en) m_busy[issue_dst] = 1'b1;
            step();
        end
        idle();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
